// File: rtl/cnn_frame_sequencer_if.sv
// Stream bundle around the CNN frame sequencer.
// The s_* group carries frame beats into the sequencer and the m_* group
// carries results out of it. The slave modport is the sequencer's view;
// the master modport is the surrounding environment's view.
interface cnn_frame_sequencer_if;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_last;

  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_err;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_err
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_err
  );
endinterface

// File: rtl/cnn_frame_sequencer.sv
// CNN frame sequencer.
// Collects one frame (IMG_DIM*IMG_DIM row-major pixel beats followed by one
// label beat), hands it to the CNN top with a one-cycle start pulse, waits
// for completion and returns the CNN result over a valid/ready stream.
// Frames whose s_last lands on the wrong beat are dropped and counted.
// Optional feature macro: CNN_SEQ_TIMEOUT_EN adds a WAIT timeout that
// returns 16'h8000 with m_err set when the CNN top never completes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_LOAD  | accepting pixel/label beats of a frame
// ST_DRAIN | frame overran its length; discard beats up to s_last
// ST_START | frame complete; cnn_start pulses for this single cycle
// ST_WAIT  | waiting for cnn_done (optionally bounded by a timeout)
// ST_OUT   | result presented on m_*; held until m_ready
module cnn_frame_sequencer #(
  parameter int IMG_DIM        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  cnn_frame_sequencer_if.slave                  bus,
  output logic [IMG_DIM-1:0][IMG_DIM-1:0][15:0] image,
  output logic [15:0]                           label,
  output logic                                  cnn_start,
  input  logic                                  cnn_done,
  input  logic [15:0]                           cnn_result,
  output logic [7:0]                            frame_err_cnt
);

  localparam int N     = IMG_DIM * IMG_DIM;
  localparam int IDX_W = $clog2(N + 1);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_DRAIN,
    ST_START,
    ST_WAIT,
    ST_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_inc;
  logic             load_beat;
  logic             at_label;
  logic             tmo_hit;
  logic [15:0]      m_data_q;

  // The beat index reaching N means the next accepted beat is the label.
  assign at_label  = (idx_q == IDX_W'(N));
  assign load_beat = (state_q == ST_LOAD) && bus.s_valid;

`ifdef CNN_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             m_err_q;

  // The last allowed WAIT cycle is the one where the count reads TIMEOUT_CYCLES-1.
  assign tmo_hit   = (state_q == ST_WAIT) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign bus.m_err = m_err_q;

  // WAIT-cycle counter: cleared while the start pulse goes out, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_START) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

  // Error flag: cleared by a real result, set by a timeout; cnn_done wins a tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_err_q <= 1'b0;
    end else if (state_q == ST_WAIT) begin
      if (cnn_done) begin
        m_err_q <= 1'b0;
      end else if (tmo_hit) begin
        m_err_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign bus.m_err = 1'b0;
`endif

  assign bus.m_data = m_data_q;

  // State and beat-index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state, beat index, error strobe and handshake outputs.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    err_inc       = 1'b0;
    bus.s_ready   = 1'b0;
    bus.m_valid   = 1'b0;
    cnn_start     = 1'b0;

    case (state_q)
      ST_LOAD: begin
        bus.s_ready = !rst;
        if (bus.s_valid) begin
          if (at_label) begin
            idx_d = '0;
            if (bus.s_last) begin
              state_d = ST_START;
            end else begin
              err_inc = 1'b1;
              state_d = ST_DRAIN;
            end
          end else if (bus.s_last) begin
            idx_d   = '0;
            err_inc = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        bus.s_ready = !rst;
        if (bus.s_valid && bus.s_last) begin
          state_d = ST_LOAD;
        end
      end
      ST_START: begin
        cnn_start = !rst;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnn_done || tmo_hit) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        bus.m_valid = !rst;
        if (bus.m_ready) begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
        idx_d   = '0;
      end
    endcase
  end

  // Image/label capture; only LOAD writes them, so they are frozen while the CNN runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      image <= '0;
      label <= '0;
    end else if (load_beat) begin
      if (at_label) begin
        label <= bus.s_data;
      end else begin
        for (int r = 0; r < IMG_DIM; r++) begin
          for (int c = 0; c < IMG_DIM; c++) begin
            if (idx_q == IDX_W'(r * IMG_DIM + c)) begin
              image[r][c] <= bus.s_data;
            end
          end
        end
      end
    end
  end

  // Result capture: CNN output on completion, otherwise the timeout marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data_q <= '0;
    end else if (state_q == ST_WAIT) begin
      if (cnn_done) begin
        m_data_q <= cnn_result;
      end else if (tmo_hit) begin
        m_data_q <= 16'h8000;
      end
    end
  end

  // Malformed-frame counter, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_cnt <= '0;
    end else if (err_inc && (frame_err_cnt != 8'hFF)) begin
      frame_err_cnt <= frame_err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Testbench for cnn_frame_sequencer: directed frames with literal expectations,
// then randomized frames (good, short, overlong, interrupted by reset) checked
// every cycle against a frame-level behavioural model.
module tb_cnn_frame_sequencer;
  localparam int IMG_DIM        = 4;
  localparam int N              = IMG_DIM * IMG_DIM;
  localparam int TIMEOUT_CYCLES = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cnn_frame_sequencer_if bus();

  logic [IMG_DIM-1:0][IMG_DIM-1:0][15:0] image;
  logic [15:0] label;
  logic        cnn_start;
  logic        cnn_done;
  logic [15:0] cnn_result;
  logic [7:0]  frame_err_cnt;

  cnn_frame_sequencer #(.IMG_DIM(IMG_DIM), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .image        (image),
    .label        (label),
    .cnn_start    (cnn_start),
    .cnn_done     (cnn_done),
    .cnn_result   (cnn_result),
    .frame_err_cnt(frame_err_cnt)
  );

  int checks   = 0;
  int failures = 0;
  int starts_seen = 0;
  bit chk_en = 1'b0;

  // CNN/downstream side: either directed values or random background.
  bit          bg_en = 1'b0;
  logic        dir_done = 1'b0, rnd_done = 1'b0;
  logic [15:0] dir_result = 16'h0, rnd_result = 16'h0;
  logic        dir_ready = 1'b0, rnd_ready = 1'b0;
  assign cnn_done     = bg_en ? rnd_done   : dir_done;
  assign cnn_result   = bg_en ? rnd_result : dir_result;
  assign bus.m_ready  = bg_en ? rnd_ready  : dir_ready;

  always @(posedge clk) begin
    #1;
    rnd_done   = ($urandom_range(0, 5) == 0);
    rnd_result = 16'($urandom);
    rnd_ready  = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) if (cnn_start) starts_seen++;

  // ---------------- behavioural model ----------------
  logic [IMG_DIM-1:0][IMG_DIM-1:0][15:0] md_img = '0;
  logic [15:0] md_label = 0, md_mdata = 0;
  logic        md_merr = 0;
  int          md_idx = 0, md_errs = 0, md_wcnt = 0;
  bit          md_drain = 0, md_start = 0, md_wait = 0, md_out = 0;

  always @(posedge clk) begin
    if (rst) begin
      md_img = '0; md_label = 0; md_mdata = 0; md_merr = 0;
      md_idx = 0; md_errs = 0; md_wcnt = 0;
      md_drain = 0; md_start = 0; md_wait = 0; md_out = 0;
    end else if (md_start) begin
      md_start = 0; md_wait = 1; md_wcnt = 0;
    end else if (md_wait) begin
      md_wcnt++;
      if (cnn_done) begin
        md_mdata = cnn_result; md_merr = 0; md_wait = 0; md_out = 1;
      end
`ifdef CNN_SEQ_TIMEOUT_EN
      else if (md_wcnt == TIMEOUT_CYCLES) begin
        md_mdata = 16'h8000; md_merr = 1; md_wait = 0; md_out = 1;
      end
`endif
    end else if (md_out) begin
      if (bus.m_ready) md_out = 0;
    end else if (bus.s_valid) begin
      if (md_drain) begin
        if (bus.s_last) md_drain = 0;
      end else if (md_idx < N) begin
        md_img[md_idx / IMG_DIM][md_idx % IMG_DIM] = bus.s_data;
        if (bus.s_last) begin
          if (md_errs < 255) md_errs++;
          md_idx = 0;
        end else begin
          md_idx++;
        end
      end else begin
        md_label = bus.s_data;
        md_idx = 0;
        if (bus.s_last) md_start = 1;
        else begin
          if (md_errs < 255) md_errs++;
          md_drain = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_ready",   32'(bus.s_ready), 32'(!rst && !(md_start || md_wait || md_out)));
      chk("cnn_start", 32'(cnn_start),   32'(!rst && md_start));
      chk("m_valid",   32'(bus.m_valid), 32'(!rst && md_out));
      chk("m_data",    32'(bus.m_data),  32'(md_mdata));
      chk("m_err",     32'(bus.m_err),   32'(md_merr));
      chk("label",     32'(label),       32'(md_label));
      chk("frame_err_cnt", 32'(frame_err_cnt), 32'(md_errs));
      checks++;
      if (image !== md_img) begin
        failures++;
        $display("FAIL image actual=%h required=%h time=%0t", image, md_img, $time);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l);
    int  n;
    logic r;
    n = 0;
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = l;
    while (1) begin
      @(negedge clk); r = bus.s_ready;
      step();
      if (r) break;
      n++;
      if (n > 400) begin
        checks++; failures++;
        $display("FAIL s_ready_wait actual=0 required=1 within 400 cycles time=%0t", $time);
        break;
      end
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", 32'(bus.s_ready), 32'd1);
    step();
  endtask

  task automatic send_directed_frame();
    for (int k = 0; k < N; k++) send_beat(16'((k + 1) * 256), 1'b0);
    send_beat(16'h0080, 1'b1);
  endtask

  // kind 0: well formed, 1: s_last on pixel beat 'extra', 2: 'extra' beats past the label
  task automatic send_frame(input int kind, input int extra);
    int len;
    if (kind == 0) len = N + 1;
    else if (kind == 1) len = extra + 1;
    else len = N + 1 + extra;
    for (int k = 0; k < len; k++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
      if ($urandom_range(0, 80) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
      send_beat(16'($urandom), 1'(k == len - 1));
    end
  endtask

  int s0;
  int kind;

  initial begin
    bus.s_valid = 1'b0; bus.s_data = 16'h0; bus.s_last = 1'b0;
    step();
    chk_en = 1'b1;
    do_reset();

    // Well-formed frame, start pulse timing, result hold under back-pressure.
    s0 = starts_seen;
    send_directed_frame();
    @(negedge clk);
    chk("start_after_last", 32'(cnn_start), 32'd1);
    chk("image_3_3", 32'(image[3][3]), 32'h1000);
    chk("image_0_0", 32'(image[0][0]), 32'h0100);
    chk("label_val", 32'(label), 32'h0080);
    step();
    @(negedge clk);
    chk("start_one_cycle", 32'(cnn_start), 32'd0);
    step();
    dir_result = 16'hFF40; dir_done = 1'b1;
    step();
    dir_done = 1'b0;
    @(negedge clk);
    chk("m_valid_D1", 32'(bus.m_valid), 32'd1);
    chk("m_data_D1", 32'(bus.m_data), 32'hFF40);
    chk("m_err_D1", 32'(bus.m_err), 32'd0);
    repeat (5) begin
      step();
      @(negedge clk);
      chk("hold_m_valid", 32'(bus.m_valid), 32'd1);
      chk("hold_m_data", 32'(bus.m_data), 32'hFF40);
      chk("hold_s_ready", 32'(bus.s_ready), 32'd0);
    end
    step();
    dir_ready = 1'b1;
    step();
    dir_ready = 1'b0;
    @(negedge clk);
    chk("after_hs_m_valid", 32'(bus.m_valid), 32'd0);
    chk("after_hs_s_ready", 32'(bus.s_ready), 32'd1);
    chk("single_start", 32'(starts_seen - s0), 32'd1);
    step();

    // Early s_last on the fifth beat, then a good frame.
    do_reset();
    s0 = starts_seen;
    for (int k = 0; k < 4; k++) send_beat(16'(k), 1'b0);
    send_beat(16'h0005, 1'b1);
    @(negedge clk);
    chk("short_no_start", 32'(starts_seen - s0), 32'd0);
    chk("short_err_cnt", 32'(frame_err_cnt), 32'd1);
    step();
    send_directed_frame();
    @(negedge clk);
    chk("recover_start", 32'(cnn_start), 32'd1);
    step();
    step();
    dir_done = 1'b1; dir_result = 16'h1234;
    step();
    dir_done = 1'b0; dir_ready = 1'b1;
    step();
    dir_ready = 1'b0;

    // Overlong frame: 17 beats without s_last, then 3 drained beats.
    do_reset();
    s0 = starts_seen;
    for (int k = 0; k <= N; k++) send_beat(16'(16'hA000 + k), 1'b0);
    send_beat(16'h1111, 1'b0);
    send_beat(16'h2222, 1'b0);
    send_beat(16'h3333, 1'b1);
    @(negedge clk);
    chk("long_no_start", 32'(starts_seen - s0), 32'd0);
    chk("long_err_cnt", 32'(frame_err_cnt), 32'd1);
    chk("long_back_load", 32'(bus.s_ready), 32'd1);
    step();
    send_beat(16'h0777, 1'b0);
    @(negedge clk);
    chk("long_idx0", 32'(image[0][0]), 32'h0777);
    step();

    // Reset while waiting on the CNN, then a late cnn_done.
    do_reset();
    send_directed_frame();
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    dir_done = 1'b1; dir_result = 16'h7777;
    step();
    dir_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rstwait_m_valid", 32'(bus.m_valid), 32'd0);
      chk("rstwait_m_data", 32'(bus.m_data), 32'd0);
      chk("rstwait_label", 32'(label), 32'd0);
      chk("rstwait_img", 32'(image[3][3]), 32'd0);
      step();
    end

`ifdef CNN_SEQ_TIMEOUT_EN
    // No completion: timeout marker after TIMEOUT_CYCLES WAIT cycles.
    do_reset();
    send_directed_frame();
    repeat (TIMEOUT_CYCLES) step();
    @(negedge clk);
    chk("tmo_not_yet", 32'(bus.m_valid), 32'd0);
    step();
    @(negedge clk);
    chk("tmo_m_valid", 32'(bus.m_valid), 32'd1);
    chk("tmo_m_data", 32'(bus.m_data), 32'h8000);
    chk("tmo_m_err", 32'(bus.m_err), 32'd1);
    step();
    dir_ready = 1'b1;
    step();
    dir_ready = 1'b0;
`endif

    // Error counter saturation.
    do_reset();
    repeat (260) send_beat(16'h0001, 1'b1);
    @(negedge clk);
    chk("err_saturate", 32'(frame_err_cnt), 32'd255);
    step();

    // Randomized traffic against the model.
    do_reset();
    bg_en = 1'b1;
    for (int f = 0; f < 80; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
      if (kind <= 6) send_frame(0, 0);
      else if (kind == 7) send_frame(1, $urandom_range(0, N - 1));
      else send_frame(2, $urandom_range(1, 4));
    end
    repeat (100) step();
    bg_en = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
